// File: rtl/patmos_wb_ctrl_slave_pkg.sv
// Shared definitions for the Patmos Wishbone control slave: register offsets,
// FSM state type and the byte-lane merge helper.
package patmos_wb_pkg;

  localparam logic [7:0] OFF_BOOT_ADDR = 8'h00;
  localparam logic [7:0] OFF_STALL     = 8'h04;
  localparam logic [7:0] OFF_RESET     = 8'h08;
  localparam logic [7:0] OFF_DATA_ODD  = 8'h0C;
  localparam logic [7:0] OFF_ADDR_ODD  = 8'h10;
  localparam logic [7:0] OFF_EN_ODD    = 8'h14;
  localparam logic [7:0] OFF_DATA_EVEN = 8'h18;
  localparam logic [7:0] OFF_ADDR_EVEN = 8'h1C;
  localparam logic [7:0] OFF_EN_EVEN   = 8'h20;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic {ST_IDLE, ST_ACK} wb_state_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = old_val;
    for (int unsigned b = 0; b < 4; b++) begin
      if (sel[b]) r[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/patmos_wb_ctrl_slave_if.sv
// Wishbone classic slave-side bus bundle used between the management core and the control slave.
interface patmos_wb_ctrl_slave_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/patmos_wb_ctrl_slave_byte_reg.sv
// 32-bit register with per-byte write enables and synchronous active-low reset to zero.
module wb_byte_reg
  import patmos_wb_pkg::*;
(
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] d_i,
  output logic [31:0] q_o
);

  logic [31:0] val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (we_i) val_d = byte_merge(val_q, d_i, sel_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) val_q <= '0;
    else         val_q <= val_d;
  end

  assign q_o = val_q;

endmodule

// File: rtl/patmos_wb_ctrl_slave.sv
// Wishbone classic responder configuring Patmos: boot address, stall, reset and boot-memory bank writes.
module patmos_wb_ctrl_slave
  import patmos_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned BMEM_AW   = 10,
  parameter logic [31:0] ERR_DATA  = ERR_DATA_DEFAULT
) (
  input  logic               wb_clk_i,
  input  logic               wb_rstn_i,
  patmos_wb_ctrl_slave_if.slave wbs,
  output logic [31:0]        boot_addr_o,
  output logic               stall_o,
  output logic               core_rst_o,
  output logic               bmem_odd_we_o,
  output logic [BMEM_AW-1:0] bmem_odd_addr_o,
  output logic [31:0]        bmem_odd_data_o,
  output logic               bmem_even_we_o,
  output logic [BMEM_AW-1:0] bmem_even_addr_o,
  output logic [31:0]        bmem_even_data_o
);

  wb_state_e state_q, state_d;
  logic ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic stall_q, stall_d;
  logic core_rst_q, core_rst_d;
  logic en_odd_q, en_odd_d;
  logic en_even_q, en_even_d;
  logic [BMEM_AW-1:0] addr_odd_q, addr_odd_d;
  logic [BMEM_AW-1:0] addr_even_q, addr_even_d;

  logic wr_boot, wr_odd, wr_even;
  logic [31:0] boot_q, data_odd_q, data_even_q;
  logic [31:0] rdata, wmerge;
  logic [7:0]  offset;
  logic        req;

  assign offset = wbs.wbs_adr_i[7:0];
  assign req = wbs.wbs_cyc_i && wbs.wbs_stb_i && (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);

  wb_byte_reg u_boot_addr (
    .clk_i(wb_clk_i), .rstn_i(wb_rstn_i), .we_i(wr_boot),
    .sel_i(wbs.wbs_sel_i), .d_i(wbs.wbs_dat_i), .q_o(boot_q)
  );

  wb_byte_reg u_data_odd (
    .clk_i(wb_clk_i), .rstn_i(wb_rstn_i), .we_i(wr_odd),
    .sel_i(wbs.wbs_sel_i), .d_i(wbs.wbs_dat_i), .q_o(data_odd_q)
  );

  wb_byte_reg u_data_even (
    .clk_i(wb_clk_i), .rstn_i(wb_rstn_i), .we_i(wr_even),
    .sel_i(wbs.wbs_sel_i), .d_i(wbs.wbs_dat_i), .q_o(data_even_q)
  );

  always_comb begin
    rdata = ERR_DATA;
    case (offset)
      OFF_BOOT_ADDR: rdata = boot_q;
      OFF_STALL:     rdata = {31'b0, stall_q};
      OFF_RESET:     rdata = {31'b0, core_rst_q};
      OFF_DATA_ODD:  rdata = data_odd_q;
      OFF_ADDR_ODD:  rdata = {{(32-BMEM_AW){1'b0}}, addr_odd_q};
      OFF_EN_ODD:    rdata = {31'b0, en_odd_q};
      OFF_DATA_EVEN: rdata = data_even_q;
      OFF_ADDR_EVEN: rdata = {{(32-BMEM_AW){1'b0}}, addr_even_q};
      OFF_EN_EVEN:   rdata = {31'b0, en_even_q};
      default:       rdata = ERR_DATA;
    endcase
  end

  // Narrow fields take their bits from the addressed register merged with the new bytes,
  // so byte enables and ignored upper bits fall out of one merge.
  assign wmerge = byte_merge(rdata, wbs.wbs_dat_i, wbs.wbs_sel_i);

  always_comb begin
    state_d     = state_q;
    ack_d       = 1'b0;
    dat_d       = '0;
    stall_d     = stall_q;
    core_rst_d  = core_rst_q;
    en_odd_d    = en_odd_q;
    en_even_d   = en_even_q;
    addr_odd_d  = addr_odd_q;
    addr_even_d = addr_even_q;
    wr_boot     = 1'b0;
    wr_odd      = 1'b0;
    wr_even     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          if (wbs.wbs_we_i) begin
            case (offset)
              OFF_BOOT_ADDR: wr_boot     = 1'b1;
              OFF_STALL:     stall_d     = wmerge[0];
              OFF_RESET:     core_rst_d  = wmerge[0];
              OFF_DATA_ODD:  wr_odd      = 1'b1;
              OFF_ADDR_ODD:  addr_odd_d  = wmerge[BMEM_AW-1:0];
              OFF_EN_ODD:    en_odd_d    = wmerge[0];
              OFF_DATA_EVEN: wr_even     = 1'b1;
              OFF_ADDR_EVEN: addr_even_d = wmerge[BMEM_AW-1:0];
              OFF_EN_EVEN:   en_even_d   = wmerge[0];
              default: ;
            endcase
          end else begin
            dat_d = rdata;
          end
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rstn_i) begin
      state_q     <= ST_IDLE;
      ack_q       <= 1'b0;
      dat_q       <= '0;
      stall_q     <= 1'b0;
      core_rst_q  <= 1'b1;
      en_odd_q    <= 1'b0;
      en_even_q   <= 1'b0;
      addr_odd_q  <= '0;
      addr_even_q <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      stall_q     <= stall_d;
      core_rst_q  <= core_rst_d;
      en_odd_q    <= en_odd_d;
      en_even_q   <= en_even_d;
      addr_odd_q  <= addr_odd_d;
      addr_even_q <= addr_even_d;
    end
  end

  assign wbs.wbs_ack_o    = ack_q;
  assign wbs.wbs_dat_o    = dat_q;
  assign boot_addr_o      = boot_q;
  assign stall_o          = stall_q;
  assign core_rst_o       = core_rst_q;
  assign bmem_odd_we_o    = en_odd_q;
  assign bmem_odd_addr_o  = addr_odd_q;
  assign bmem_odd_data_o  = data_odd_q;
  assign bmem_even_we_o   = en_even_q;
  assign bmem_even_addr_o = addr_even_q;
  assign bmem_even_data_o = data_even_q;

endmodule

// File: tb/tb_patmos_wb_ctrl_slave.sv
// Directed bench for patmos_wb_ctrl_slave with a read-data scoreboard queue.
module tb_patmos_wb_ctrl_slave;
  import patmos_wb_pkg::*;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic clk = 1'b0;
  logic rstn;
  logic [31:0] boot_addr;
  logic stall, core_rst;
  logic odd_we, even_we;
  logic [9:0] odd_addr, even_addr;
  logic [31:0] odd_data, even_data;

  int tests = 0;
  int failed = 0;
  logic [31:0] exp_q[$];

  patmos_wb_ctrl_slave_if bus ();

  patmos_wb_ctrl_slave #(.BASE_ADDR(BASE), .BMEM_AW(10), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .wb_clk_i(clk), .wb_rstn_i(rstn), .wbs(bus.slave),
    .boot_addr_o(boot_addr), .stall_o(stall), .core_rst_o(core_rst),
    .bmem_odd_we_o(odd_we), .bmem_odd_addr_o(odd_addr), .bmem_odd_data_o(odd_data),
    .bmem_even_we_o(even_we), .bmem_even_addr_o(even_addr), .bmem_even_data_o(even_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one transfer, waits a bounded number of edges for ack, checks latency and read data.
  task automatic xfer(input string tag, input logic we, input logic [31:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel,
                      input logic exp_ack, input logic [31:0] exp_rd);
    int cyc;
    logic got;
    logic [31:0] e;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_adr_i = adr;  bus.wbs_dat_i = dat;  bus.wbs_sel_i = sel;
    if (!we && exp_ack) exp_q.push_back(exp_rd);
    got = 1'b0;
    cyc = 0;
    for (int i = 0; i < 4 && !got; i++) begin
      step();
      cyc++;
      if (bus.wbs_ack_o === 1'b1) got = 1'b1;
    end
    check({tag, "_ack"}, {31'b0, got}, {31'b0, exp_ack});
    if (got) begin
      check({tag, "_lat"}, cyc, 1);
      if (!we && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({tag, "_rd"}, bus.wbs_dat_o, e);
      end
    end
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    step();
    check({tag, "_ackdrop"}, {31'b0, bus.wbs_ack_o}, 32'h0);
  endtask

  initial begin
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = '0;   bus.wbs_dat_i = '0;
    rstn = 1'b0;
    repeat (3) step();
    rstn = 1'b1;
    step();

    check("rst_core_rst", {31'b0, core_rst}, 32'h1);
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_boot", boot_addr, 32'h0);
    check("rst_ack", {31'b0, bus.wbs_ack_o}, 32'h0);
    check("rst_dat", bus.wbs_dat_o, 32'h0);
    xfer("rd_reset", 1'b0, BASE + 32'h08, '0, 4'h0, 1'b1, 32'h1);

    xfer("wr_boot", 1'b1, BASE + 32'h00, 32'h123, 4'hF, 1'b1, '0);
    check("boot_out", boot_addr, 32'h123);
    xfer("rd_boot", 1'b0, BASE + 32'h00, '0, 4'h0, 1'b1, 32'h123);

    xfer("wr_stall", 1'b1, BASE + 32'h04, 32'h1, 4'hF, 1'b1, '0);
    xfer("wr_rst", 1'b1, BASE + 32'h08, 32'h0, 4'hF, 1'b1, '0);
    check("stall_out", {31'b0, stall}, 32'h1);
    check("core_rst_out", {31'b0, core_rst}, 32'h0);
    xfer("rd_stall", 1'b0, BASE + 32'h04, '0, 4'h0, 1'b1, 32'h1);
    xfer("rd_rst", 1'b0, BASE + 32'h08, '0, 4'h0, 1'b1, 32'h0);

    xfer("wr_dodd", 1'b1, BASE + 32'h0C, 32'h501, 4'hF, 1'b1, '0);
    xfer("wr_aodd", 1'b1, BASE + 32'h10, 32'hFFFF_F044, 4'hF, 1'b1, '0);
    xfer("wr_eodd", 1'b1, BASE + 32'h14, 32'h1, 4'hF, 1'b1, '0);
    check("odd_data", odd_data, 32'h501);
    check("odd_addr", {22'b0, odd_addr}, 32'h044);
    check("odd_we", {31'b0, odd_we}, 32'h1);
    xfer("rd_dodd", 1'b0, BASE + 32'h0C, '0, 4'h0, 1'b1, 32'h501);
    xfer("rd_aodd", 1'b0, BASE + 32'h10, '0, 4'h0, 1'b1, 32'h044);
    xfer("rd_eodd", 1'b0, BASE + 32'h14, '0, 4'h0, 1'b1, 32'h1);

    xfer("wr_deven", 1'b1, BASE + 32'h18, 32'h78, 4'hF, 1'b1, '0);
    xfer("wr_aeven", 1'b1, BASE + 32'h1C, 32'h12, 4'hF, 1'b1, '0);
    xfer("wr_eeven", 1'b1, BASE + 32'h20, 32'h1, 4'hF, 1'b1, '0);
    check("even_data", even_data, 32'h78);
    check("even_addr", {22'b0, even_addr}, 32'h012);
    check("even_we", {31'b0, even_we}, 32'h1);
    xfer("rd_deven", 1'b0, BASE + 32'h18, '0, 4'h0, 1'b1, 32'h78);
    xfer("rd_aeven", 1'b0, BASE + 32'h1C, '0, 4'h0, 1'b1, 32'h12);
    xfer("rd_eeven", 1'b0, BASE + 32'h20, '0, 4'h0, 1'b1, 32'h1);

    xfer("wr_boot_sel", 1'b1, BASE + 32'h00, 32'hAABB_CCDD, 4'b0010, 1'b1, '0);
    check("boot_sel", boot_addr, 32'h0000_CC23);
    xfer("wr_boot_sel0", 1'b1, BASE + 32'h00, 32'hFFFF_FFFF, 4'b0000, 1'b1, '0);
    check("boot_sel0", boot_addr, 32'h0000_CC23);
    xfer("wr_unmapped", 1'b1, BASE + 32'h24, 32'h1234_5678, 4'hF, 1'b1, '0);
    xfer("rd_unmapped", 1'b0, BASE + 32'h3C, '0, 4'h0, 1'b1, 32'hDEAD_BEEF);
    xfer("wr_en_hi", 1'b1, BASE + 32'h14, 32'hFFFF_FFFE, 4'hF, 1'b1, '0);
    check("odd_we_clr", {31'b0, odd_we}, 32'h0);

    // Held request: accepted, acked, then re-accepted after the ACK cycle.
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
    bus.wbs_adr_i = BASE + 32'h00;
    step(); check("b2b_ack0", {31'b0, bus.wbs_ack_o}, 32'h1);
    step(); check("b2b_ack1", {31'b0, bus.wbs_ack_o}, 32'h0);
    step(); check("b2b_ack2", {31'b0, bus.wbs_ack_o}, 32'h1);
    check("b2b_rd", bus.wbs_dat_o, 32'h0000_CC23);
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    step();

    xfer("oow_rd", 1'b0, 32'h3000_0100, '0, 4'h0, 1'b0, '0);
    xfer("oow_wr", 1'b1, 32'h2000_0000, 32'h5, 4'hF, 1'b0, '0);
    check("oow_boot", boot_addr, 32'h0000_CC23);

    // Reset during ACK with the request still held.
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
    bus.wbs_adr_i = BASE + 32'h04;
    step(); check("mid_ack", {31'b0, bus.wbs_ack_o}, 32'h1);
    rstn = 1'b0;
    step(); check("mid_rst_ack0", {31'b0, bus.wbs_ack_o}, 32'h0);
    step(); check("mid_rst_ack1", {31'b0, bus.wbs_ack_o}, 32'h0);
    check("mid_rst_boot", boot_addr, 32'h0);
    check("mid_rst_stall", {31'b0, stall}, 32'h0);
    check("mid_rst_core", {31'b0, core_rst}, 32'h1);
    check("mid_rst_even", {even_we, 21'b0, even_addr}, 32'h0);
    check("mid_rst_edata", even_data, 32'h0);
    check("mid_rst_odata", odd_data, 32'h0);
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    rstn = 1'b1;
    step();
    check("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
